// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Program counter and byte-serial instruction fetch stage. Reads four
// consecutive bytes from an 8-bit instruction memory, packs them big-endian
// into a 32-bit instruction and hands it downstream over valid/ready.
// Accepts redirects (branch/jump) and stops at the end of memory.
//
// Optional feature macro: FETCH_WRAP_EN
//   defined   -> end of memory wraps PC to 0; redirect targets are reduced
//                modulo INSTR_MAX; Done is tied low; HALT is unreachable.
//   undefined -> fetch halts after the last instruction (Done=1).
//
// Parameters:
//   INSTR_MAX     instruction memory size in bytes (multiple of 4)
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   MemAddr       byte address to instruction memory
//   MemData       byte at MemAddr (combinational read)
//   Instr         assembled instruction
//   AddrOut       PC of Instr
//   InstrValid    Instr/AddrOut valid
//   InstrReady    downstream accepts the instruction
//   Redirect      load a new PC
//   RedirectAddr  new PC (bits [1:0] ignored)
//   Done          fetch halted at end of memory
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned INSTR_MAX = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] MemAddr,
  input  logic [7:0]  MemData,
  output logic [31:0] Instr,
  output logic [31:0] AddrOut,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddr,
  output logic        Done
);

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_HALT    = 2'd2;

  localparam logic [31:0] MAX_ADDR = 32'(INSTR_MAX);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic [1:0]  state_q, state_d;

  logic [31:0] pc_plus4;
  logic [31:0] redir_tgt;

  // Low address bits of a redirect are architecturally ignored.
  logic unused_redir_bits;
  assign unused_redir_bits = ^RedirectAddr[1:0];

  assign pc_plus4  = pc_q + 32'd4;
  assign redir_tgt = {RedirectAddr[31:2], 2'b00};

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    state_d = state_q;

    if (Redirect) begin
      // Redirect wins over everything, including a same-edge handshake.
      cnt_d = 2'd0;
`ifdef FETCH_WRAP_EN
      pc_d    = redir_tgt % MAX_ADDR;
      state_d = ST_FETCH;
`else
      pc_d    = redir_tgt;
      state_d = (redir_tgt >= MAX_ADDR) ? ST_HALT : ST_FETCH;
`endif
    end else begin
      case (state_q)
        ST_FETCH: begin
          // Big-endian: first byte lands in the top lane.
          case (cnt_q)
            2'd0:    instr_d[31:24] = MemData;
            2'd1:    instr_d[23:16] = MemData;
            2'd2:    instr_d[15:8]  = MemData;
            default: instr_d[7:0]   = MemData;
          endcase
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (InstrReady) begin
            if (pc_plus4 == MAX_ADDR) begin
`ifdef FETCH_WRAP_EN
              pc_d    = 32'd0;
              state_d = ST_FETCH;
`else
              pc_d    = pc_plus4;
              state_d = ST_HALT;
`endif
            end else begin
              pc_d    = pc_plus4;
              state_d = ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_FETCH;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= 32'd0;
      cnt_q   <= 2'd0;
      instr_q <= 32'd0;
      state_q <= ST_FETCH;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      state_q <= state_d;
    end
  end

  assign MemAddr    = (state_q == ST_FETCH) ? (pc_q + {30'd0, cnt_q}) : pc_q;
  assign Instr      = instr_q;
  assign AddrOut    = pc_q;
  assign InstrValid = (state_q == ST_PRESENT);
`ifdef FETCH_WRAP_EN
  assign Done       = 1'b0;
`else
  assign Done       = (state_q == ST_HALT);
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int MAXB = 128;

  logic        clk;
  logic        rst_n;
  logic [31:0] MemAddr;
  logic [7:0]  MemData;
  logic [31:0] Instr;
  logic [31:0] AddrOut;
  logic        InstrValid;
  logic        InstrReady;
  logic        Redirect;
  logic [31:0] RedirectAddr;
  logic        Done;

  int n_checks;
  int n_fail;

  logic [7:0] mem [0:MAXB-1];

  instr_fetch_unit #(.INSTR_MAX(MAXB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .MemAddr      (MemAddr),
    .MemData      (MemData),
    .Instr        (Instr),
    .AddrOut      (AddrOut),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .Redirect     (Redirect),
    .RedirectAddr (RedirectAddr),
    .Done         (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign MemData = (MemAddr < 32'(MAXB)) ? mem[MemAddr[6:0]] : 8'h00;

  function automatic logic [31:0] exp_instr(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", InstrValid); end
    n_checks++; if (Instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr got %h want 0", Instr); end
    n_checks++; if (MemAddr !== 32'd0) begin n_fail++; $display("FAIL reset_memaddr got %h want 0", MemAddr); end
    n_checks++; if (AddrOut !== 32'd0) begin n_fail++; $display("FAIL reset_addrout got %h want 0", AddrOut); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", Done); end
    $display("reset: checked outputs");
  endtask

  task automatic test_first_fetch;
    InstrReady = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (MemAddr !== 32'(i)) begin n_fail++; $display("FAIL first_memaddr%0d got %h want %h", i, MemAddr, i); end
      n_checks++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL first_early_valid%0d got %b want 0", i, InstrValid); end
      @(negedge clk);
    end
    n_checks++; if (InstrValid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b want 1", InstrValid); end
    n_checks++; if (Instr !== 32'h8C220004) begin n_fail++; $display("FAIL first_instr got %h want 8c220004", Instr); end
    n_checks++; if (AddrOut !== 32'd0) begin n_fail++; $display("FAIL first_addrout got %h want 0", AddrOut); end
    @(negedge clk);
    n_checks++; if (AddrOut !== 32'd4) begin n_fail++; $display("FAIL first_next_addrout got %h want 4", AddrOut); end
    n_checks++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL first_next_valid got %b want 0", InstrValid); end
    $display("first fetch: instr %h at %h handed over", 32'h8C220004, 0);
  endtask

  task automatic test_stall;
    InstrReady = 1'b0;
    repeat (4) @(negedge clk);
    for (int c = 0; c < 11; c++) begin
      n_checks++; if (InstrValid !== 1'b1) begin n_fail++; $display("FAIL stall_valid c%0d got %b want 1", c, InstrValid); end
      n_checks++; if (AddrOut !== 32'd4) begin n_fail++; $display("FAIL stall_addrout c%0d got %h want 4", c, AddrOut); end
      n_checks++; if (Instr !== exp_instr(4)) begin n_fail++; $display("FAIL stall_instr c%0d got %h want %h", c, Instr, exp_instr(4)); end
      if (c < 10) @(negedge clk);
    end
    InstrReady = 1'b1;
    @(negedge clk);
    InstrReady = 1'b0;
    n_checks++; if (AddrOut !== 32'd8) begin n_fail++; $display("FAIL stall_release_addrout got %h want 8", AddrOut); end
    n_checks++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL stall_release_valid got %b want 0", InstrValid); end
    $display("stall: held 10 cycles, released to pc 8");
  endtask

  task automatic test_redirect_mid;
    repeat (2) @(negedge clk);
    n_checks++; if (MemAddr !== 32'h0A) begin n_fail++; $display("FAIL redir_pre_memaddr got %h want 0a", MemAddr); end
    Redirect = 1'b1;
    RedirectAddr = 32'h0000_0023;
    @(negedge clk);
    Redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (MemAddr !== 32'(32'h20 + i)) begin n_fail++; $display("FAIL redir_memaddr%0d got %h want %h", i, MemAddr, 32'h20 + i); end
      @(negedge clk);
    end
    n_checks++; if (InstrValid !== 1'b1) begin n_fail++; $display("FAIL redir_valid got %b want 1", InstrValid); end
    n_checks++; if (AddrOut !== 32'h20) begin n_fail++; $display("FAIL redir_addrout got %h want 20", AddrOut); end
    n_checks++; if (Instr !== exp_instr(32'h20)) begin n_fail++; $display("FAIL redir_instr got %h want %h", Instr, exp_instr(32'h20)); end
    $display("redirect mid-fetch: target 0x23 -> addr 0x20");
  endtask

  task automatic test_redirect_handshake;
    InstrReady = 1'b1;
    Redirect = 1'b1;
    RedirectAddr = 32'h0000_0040;
    @(negedge clk);
    Redirect = 1'b0;
    InstrReady = 1'b0;
    n_checks++; if (AddrOut !== 32'h40) begin n_fail++; $display("FAIL rh_addrout got %h want 40", AddrOut); end
    n_checks++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL rh_valid got %b want 0", InstrValid); end
    repeat (4) @(negedge clk);
    n_checks++; if (InstrValid !== 1'b1) begin n_fail++; $display("FAIL rh_valid2 got %b want 1", InstrValid); end
    n_checks++; if (AddrOut !== 32'h40) begin n_fail++; $display("FAIL rh_addrout2 got %h want 40", AddrOut); end
    n_checks++; if (Instr !== exp_instr(32'h40)) begin n_fail++; $display("FAIL rh_instr got %h want %h", Instr, exp_instr(32'h40)); end
    $display("redirect+handshake: target 0x40 wins over pc+4");
  endtask

  task automatic test_reset_mid_present;
    rst_n = 1'b0;
    #1;
    n_checks++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL rmp_valid got %b want 0", InstrValid); end
    n_checks++; if (Instr !== 32'd0) begin n_fail++; $display("FAIL rmp_instr got %h want 0", Instr); end
    n_checks++; if (MemAddr !== 32'd0) begin n_fail++; $display("FAIL rmp_memaddr got %h want 0", MemAddr); end
    @(negedge clk);
    rst_n = 1'b1;
    InstrReady = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (InstrValid !== 1'b1) begin n_fail++; $display("FAIL rmp_refetch_valid got %b want 1", InstrValid); end
    n_checks++; if (AddrOut !== 32'd0) begin n_fail++; $display("FAIL rmp_refetch_addr got %h want 0", AddrOut); end
    n_checks++; if (Instr !== 32'h8C220004) begin n_fail++; $display("FAIL rmp_refetch_instr got %h want 8c220004", Instr); end
    $display("reset mid-present: refetch from 0");
  endtask

  task automatic test_run_to_end;
    int waited;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    InstrReady = 1'b1;
    for (int k = 0; k < 32; k++) begin
      waited = 0;
      while (InstrValid !== 1'b1 && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      n_checks++;
      if (InstrValid !== 1'b1) begin
        n_fail++; $display("FAIL run_timeout k%0d got valid %b want 1", k, InstrValid);
      end else begin
        if (AddrOut !== 32'(4 * k) || Instr !== exp_instr(4 * k)) begin
          n_fail++; $display("FAIL run_xfer k%0d got %h@%h want %h@%h", k, Instr, AddrOut, exp_instr(4 * k), 4 * k);
        end
        $display("run: handshake %0d instr %h addr %h", k, Instr, AddrOut);
      end
      @(negedge clk);
    end
`ifdef FETCH_WRAP_EN
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL wrap_done got %b want 0", Done); end
    waited = 0;
    while (InstrValid !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    n_checks++; if (InstrValid !== 1'b1 || AddrOut !== 32'd0) begin n_fail++; $display("FAIL wrap_33rd got %h valid %b want 0 valid 1", AddrOut, InstrValid); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL wrap_done2 got %b want 0", Done); end
    @(negedge clk);
`else
    n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL end_done got %b want 1", Done); end
    for (int c = 0; c < 10; c++) begin
      n_checks++; if (InstrValid !== 1'b0 || Done !== 1'b1) begin n_fail++; $display("FAIL halt_hold c%0d got valid %b done %b want 0 1", c, InstrValid, Done); end
      @(negedge clk);
    end
`endif
  endtask

  task automatic test_redirect_boundary;
    Redirect = 1'b1;
    RedirectAddr = 32'h0000_0203;
    @(negedge clk);
    Redirect = 1'b0;
`ifdef FETCH_WRAP_EN
    n_checks++; if (Done !== 1'b0 || MemAddr !== 32'd0) begin n_fail++; $display("FAIL oor_wrap got done %b memaddr %h want 0 0", Done, MemAddr); end
    repeat (4) @(negedge clk);
    n_checks++; if (InstrValid !== 1'b1 || AddrOut !== 32'd0) begin n_fail++; $display("FAIL oor_wrap_fetch got valid %b addr %h want 1 0", InstrValid, AddrOut); end
`else
    n_checks++; if (Done !== 1'b1 || InstrValid !== 1'b0) begin n_fail++; $display("FAIL oor_halt got done %b valid %b want 1 0", Done, InstrValid); end
    repeat (4) @(negedge clk);
    n_checks++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL oor_nofetch got valid %b want 0", InstrValid); end
`endif
    InstrReady = 1'b0;
    Redirect = 1'b1;
    RedirectAddr = 32'h0000_0010;
    @(negedge clk);
    Redirect = 1'b0;
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL resume_done got %b want 0", Done); end
    n_checks++; if (MemAddr !== 32'h10) begin n_fail++; $display("FAIL resume_memaddr got %h want 10", MemAddr); end
    repeat (4) @(negedge clk);
    n_checks++; if (InstrValid !== 1'b1 || AddrOut !== 32'h10 || Instr !== exp_instr(32'h10)) begin
      n_fail++; $display("FAIL resume_fetch got %h@%h valid %b want %h@10 valid 1", Instr, AddrOut, InstrValid, exp_instr(32'h10));
    end
    $display("redirect boundary: out-of-range target then resume at 0x10");
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    for (int i = 0; i < MAXB; i++) mem[i] = 8'((i * 13 + 5) & 8'hFF);
    mem[0] = 8'h8C; mem[1] = 8'h22; mem[2] = 8'h00; mem[3] = 8'h04;
    rst_n = 1'b0;
    InstrReady = 1'b0;
    Redirect = 1'b0;
    RedirectAddr = 32'd0;

    test_reset;
    test_first_fetch;
    test_stall;
    test_redirect_mid;
    test_redirect_handshake;
    test_reset_mid_present;
    test_run_to_end;
    test_redirect_boundary;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
